// File: rtl/spi_master_controller.sv
// SPI master that frames each 10-bit command as one SS_n-low transaction on the system clock,
// capturing an 8-bit MISO reply for read-data commands (opcode 2'b11).
module spi_master_controller #(
    parameter int CMD_SIZE  = 10,
    parameter int DATA_SIZE = 8,
    parameter int RD_LAT    = 2,
    parameter int GAP       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CMD_SIZE-1:0]  cmd_data,
    output logic                 rsp_valid,
    output logic [DATA_SIZE-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int CNT_MAX = (CMD_SIZE > DATA_SIZE) ?
                             ((CMD_SIZE > 15) ? CMD_SIZE : 15) :
                             ((DATA_SIZE > 15) ? DATA_SIZE : 15);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CMD_SIZE-1:0]    cmd_q, cmd_d;
    logic                   is_rd_q, is_rd_d;
    logic [DATA_SIZE-1:0]   rx_q, rx_d;
    logic                   ss_q, ss_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_SIZE-1:0]   rsp_data_q, rsp_data_d;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign SS_n      = ss_q;
    assign MOSI      = mosi_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            is_rd_q     <= 1'b0;
            rx_q        <= '0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            is_rd_q     <= is_rd_d;
            rx_q        <= rx_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        is_rd_d     = is_rd_q;
        rx_d        = rx_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d   = cmd_data;
                    is_rd_d = (cmd_data[CMD_SIZE-1 -: 2] == 2'b11);
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            // The MSB goes out here as the dummy bit and again on the first SHIFT edge.
            ST_START: begin
                mosi_d  = cmd_q[CMD_SIZE-1];
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(CMD_SIZE)) begin
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = is_rd_q ? ST_WAIT : ST_HOLD;
                end else begin
                    mosi_d  = cmd_q[CMD_SIZE-1];
                    cmd_d   = cmd_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_READ;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                rx_d = {rx_q[DATA_SIZE-2:0], MISO};
                if (cnt_q == CNT_W'(DATA_SIZE - 1)) begin
                    rsp_data_d  = {rx_q[DATA_SIZE-2:0], MISO};
                    rsp_valid_d = 1'b1;
                    ss_d        = 1'b1;
                    mosi_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // One extra SS_n-low cycle lets the slave reach its write-strobe state.
            ST_HOLD: begin
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_controller.sv
// Testbench for spi_master_controller: a command-level slave model supplies MISO replies and
// each transaction's pin activity is predicted cycle by cycle from the framing rules.
module tb_spi_master_controller;

    localparam int CMD_SIZE  = 10;
    localparam int DATA_SIZE = 8;
    localparam int RD_LAT    = 2;
    localparam int GAP       = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CMD_SIZE-1:0]  cmd_data;
    logic                 rsp_valid;
    logic [DATA_SIZE-1:0] rsp_data;
    logic                 busy;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;

    int checks = 0;
    int errors = 0;

    // Slave model state, updated only when a transaction completes.
    logic [7:0] mem [256];
    logic [7:0] addr_reg;
    logic [7:0] rd_addr;
    logic [DATA_SIZE-1:0] last_rd;

    spi_master_controller #(
        .CMD_SIZE(CMD_SIZE), .DATA_SIZE(DATA_SIZE), .RD_LAT(RD_LAT), .GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] slave_reply();
        return mem[rd_addr];
    endfunction

    task automatic slave_update(input logic [CMD_SIZE-1:0] cmd);
        case (cmd[9:8])
            2'b00:   addr_reg = cmd[7:0];
            2'b01:   mem[addr_reg] = cmd[7:0];
            2'b10:   rd_addr = cmd[7:0];
            default: ;
        endcase
    endtask

    // Runs one command from handshake to the first IDLE cycle, checking every cycle.
    // Called #1 after a rising edge with the DUT idle.
    task automatic do_transaction(input logic [CMD_SIZE-1:0] cmd, input logic [DATA_SIZE-1:0] reply,
                                  input bit hold, input string tag);
        bit          is_rd;
        int          lss;
        int          tend;
        logic [10:0] frame;
        logic [12:0] got, exp;
        logic        e_ss, e_mosi, e_busy, e_rdy, e_rv;
        logic [7:0]  e_rd;
        is_rd = (cmd[9:8] == 2'b11);
        lss   = 12 + (is_rd ? (RD_LAT + DATA_SIZE) : 1);
        tend  = lss + GAP;
        frame = {cmd[9], cmd};
        cmd_data  = cmd;
        cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_handshake got=%b expected=1", tag, cmd_ready);
        end
        @(posedge clk); #1;
        for (int t = 0; t <= tend; t++) begin
            if (t == 0) begin
                if (hold) cmd_data = CMD_SIZE'($urandom);
                else      cmd_valid = 1'b0;
            end
            e_ss   = (t < lss) ? 1'b0 : 1'b1;
            e_mosi = (t >= 1 && t <= 11) ? frame[11 - t] : 1'b0;
            e_busy = (t < tend);
            e_rdy  = !e_busy;
            e_rv   = is_rd && (t == lss);
            e_rd   = e_rv ? reply : last_rd;
            exp = {e_ss, e_mosi, e_busy, e_rdy, e_rv, e_rd};
            got = {SS_n, MOSI, busy, cmd_ready, rsp_valid, rsp_data};
            checks++;
            if (got !== exp) begin
                errors++;
                if (errors < 40)
                    $display("FAIL %s cmd=%h t=%0d ss/mosi/busy/rdy/rv/data got=%b expected=%b",
                             tag, cmd, t, got, exp);
            end
            if (e_rv) last_rd = reply;
            if (is_rd && t >= lss - DATA_SIZE && t < lss)
                MISO = reply[DATA_SIZE - 1 - (t - (lss - DATA_SIZE))];
            else
                MISO = 1'($urandom_range(0, 1));
            if (t < tend) begin
                @(posedge clk); #1;
            end
        end
        slave_update(cmd);
        $display("txn %s cmd=%h reply=%h rsp_data=%h", tag, cmd, reply, rsp_data);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; MISO = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({SS_n, MOSI, rsp_valid, rsp_data, busy, cmd_ready} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got ss=%b mosi=%b rv=%b rd=%h busy=%b rdy=%b expected 1 0 0 00 0 0",
                     SS_n, MOSI, rsp_valid, rsp_data, busy, cmd_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b expected=1", cmd_ready);
        end
        @(posedge clk); #1;
        last_rd = '0;
    endtask

    task automatic test_write_read();
        do_transaction(10'b00_0011_1100, '0, 1'b0, "wr_addr");
        do_transaction(10'b01_1010_0101, '0, 1'b0, "wr_data");
        do_transaction(10'b10_0011_1100, '0, 1'b0, "rd_addr");
        do_transaction(10'b11_0000_0000, slave_reply(), 1'b0, "rd_data");
        checks++;
        if (last_rd !== 8'hA5) begin
            errors++;
            $display("FAIL write_read_value got=%h expected=a5", last_rd);
        end
    endtask

    task automatic test_back_to_back();
        do_transaction(10'b00_0101_0001, '0, 1'b1, "b2b0");
        do_transaction(10'b01_1100_0011, '0, 1'b1, "b2b1");
        do_transaction(10'b00_1111_0000, '0, 1'b0, "b2b2");
    endtask

    task automatic test_read_pattern();
        do_transaction(10'b11_0000_0000, 8'h96, 1'b0, "rd_96");
        do_transaction(10'b00_0000_0111, '0, 1'b0, "wr_after_96");
        do_transaction(10'b10_0011_1100, '0, 1'b0, "rd_addr2");
        do_transaction(10'b11_0000_0000, slave_reply(), 1'b0, "rd_data2");
    endtask

    task automatic test_reset_mid_shift();
        cmd_data = 10'b00_0101_0101; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({SS_n, busy} !== 2'b01) begin
            errors++;
            $display("FAIL mid_shift_active got ss=%b busy=%b expected ss=0 busy=1", SS_n, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({SS_n, MOSI, rsp_valid, busy, cmd_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_shift_abort got ss/mosi/rv/busy/rdy=%b expected=10000",
                     {SS_n, MOSI, rsp_valid, busy, cmd_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        last_rd = '0;
        checks++;
        if ({SS_n, cmd_ready, rsp_valid, rsp_data} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL mid_shift_release got ss=%b rdy=%b rv=%b rd=%h expected 1 1 0 00",
                     SS_n, cmd_ready, rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
        do_transaction(10'b00_0011_1100, '0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        logic [CMD_SIZE-1:0] c;
        bit h;
        for (int n = 0; n < 30; n++) begin
            c = CMD_SIZE'($urandom);
            h = (n != 29) && ($urandom_range(0, 2) == 0);
            do_transaction(c, (c[9:8] == 2'b11) ? slave_reply() : 8'h00, h, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        addr_reg = '0; rd_addr = '0; last_rd = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_read_pattern();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
